// File: rtl/fixed_act_input_requant_pkg.sv
// Shared types and format helpers for the activation-input requantizer.
// Rounding bias and saturation bounds are derived from the lane formats.
package fixed_act_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_e;

    function automatic int rnd_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    function automatic longint rnd_bias(input int s);
        return (s > 0) ? (64'sd1 <<< (s - 1)) : 64'sd0;
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fixed_act_input_requant_if.sv
// Input/output stream bundle of the requantizer plus its saturation counter.
// The slave side is the requantizer, the master side is its environment.
interface fixed_act_input_requant_if #(
    parameter int IN_W = 16,
    parameter int OUT_W = 8,
    parameter int N = 1,
    parameter int CW = 32
);
    logic [N-1:0][IN_W-1:0]  data_in_0;
    logic                    data_in_0_valid;
    logic                    data_in_0_ready;
    logic [N-1:0][OUT_W-1:0] data_out_0;
    logic                    data_out_0_valid;
    logic                    data_out_0_ready;
    logic [CW-1:0]           sat_count;

    modport slave (
        input  data_in_0, data_in_0_valid, data_out_0_ready,
        output data_in_0_ready, data_out_0, data_out_0_valid, sat_count
    );

    modport master (
        output data_in_0, data_in_0_valid, data_out_0_ready,
        input  data_in_0_ready, data_out_0, data_out_0_valid, sat_count
    );
endinterface

// File: rtl/fixed_act_input_requant_round_sat.sv
// Single-lane round-half-up and saturate from the wide format to the LUT
// address format; purely combinational.
module fixed_round_sat
    import fixed_act_pkg::*;
#(
    parameter int IN_W = 16,
    parameter int IN_FRAC = 8,
    parameter int OUT_W = 8,
    parameter int OUT_FRAC = 4
) (
    input  logic [IN_W-1:0]  data_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);
    localparam int S = rnd_shift(IN_FRAC, OUT_FRAC);
    localparam logic signed [IN_W:0] RND = (IN_W + 1)'(rnd_bias(S));
    localparam logic signed [IN_W:0] MAXV = (IN_W + 1)'(sat_max(OUT_W));
    localparam logic signed [IN_W:0] MINV = (IN_W + 1)'(sat_min(OUT_W));

    if (S < 0 || (IN_W - IN_FRAC) < (OUT_W - OUT_FRAC)) begin : g_bad_fmt
        $error("fixed_round_sat: output format wider than input format");
    end

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shr;

    // One guard bit keeps the bias add from overflowing.
    assign ext = {data_i[IN_W-1], data_i};
    assign sum = ext + RND;
    assign shr = sum >>> S;

    always_comb begin
        data_o = shr[OUT_W-1:0];
        sat_o  = 1'b0;
        if (shr > MAXV) begin
            data_o = MAXV[OUT_W-1:0];
            sat_o  = 1'b1;
        end else if (shr < MINV) begin
            data_o = MINV[OUT_W-1:0];
            sat_o  = 1'b1;
        end
    end
endmodule

// File: rtl/fixed_act_input_requant.sv
// Requantizes wide accumulator lanes to the activation LUT address format
// behind a two-entry skid buffer, counting saturated lanes.
module fixed_act_input_requant
    import fixed_act_pkg::*;
#(
    parameter int DATA_IN_0_PRECISION_0 = 16,
    parameter int DATA_IN_0_PRECISION_1 = 8,
    parameter int DATA_OUT_0_PRECISION_0 = 8,
    parameter int DATA_OUT_0_PRECISION_1 = 4,
    parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
    parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
    parameter int SAT_COUNT_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    fixed_act_input_requant_if.slave bus_if
);
    localparam int N = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
    localparam int OW = DATA_OUT_0_PRECISION_0;
    localparam int CW = SAT_COUNT_WIDTH;

    logic [N-1:0][OW-1:0] rq;
    logic [N-1:0]         sat;
    logic [N-1:0][OW-1:0] out_q, out_d;
    logic [N-1:0][OW-1:0] skid_q, skid_d;
    state_e               state_q, state_d;
    logic                 rdy_q, rdy_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW:0]          pop, sum;
    logic                 accept, drain;

    for (genvar i = 0; i < N; i++) begin : g_lane
        fixed_round_sat #(
            .IN_W    (DATA_IN_0_PRECISION_0),
            .IN_FRAC (DATA_IN_0_PRECISION_1),
            .OUT_W   (DATA_OUT_0_PRECISION_0),
            .OUT_FRAC(DATA_OUT_0_PRECISION_1)
        ) u_rs (
            .data_i(bus_if.data_in_0[i]),
            .data_o(rq[i]),
            .sat_o (sat[i])
        );
    end

    assign accept = bus_if.data_in_0_valid && rdy_q;
    assign drain  = (state_q != EMPTY) && bus_if.data_out_0_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    out_d   = rq;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_d = rq;
                end else if (accept) begin
                    state_d = TWO;
                    skid_d  = rq;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        rdy_d = (state_d != TWO);
    end

    // Counter sticks at all-ones rather than wrapping.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + {{CW{1'b0}}, sat[i]};
        end
        sum   = {1'b0, cnt_q} + pop;
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = sum[CW] ? '1 : sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus_if.data_in_0_ready  = rdy_q;
    assign bus_if.data_out_0       = out_q;
    assign bus_if.data_out_0_valid = (state_q != EMPTY);
    assign bus_if.sat_count        = cnt_q;
endmodule

// File: tb/tb_fixed_act_input_requant.sv
// Directed bench: Q8.8 -> Q8.4 vector table, backpressure, reset and
// counter-saturation sequences on a default and a two-lane instance.
module tb_fixed_act_input_requant;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fixed_act_input_requant_if #(.IN_W(16), .OUT_W(8), .N(1), .CW(32)) bus ();
    fixed_act_input_requant_if #(.IN_W(16), .OUT_W(8), .N(2), .CW(4)) bus2 ();

    fixed_act_input_requant dut (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bus)
    );

    fixed_act_input_requant #(
        .DATA_IN_0_PARALLELISM_DIM_0(2),
        .SAT_COUNT_WIDTH(4)
    ) dut2 (
        .clk   (clk),
        .rst   (rst),
        .bus_if(bus2)
    );

    typedef struct {
        logic [15:0] din;
        logic [7:0]  dout;
        logic [31:0] cnt;
    } vec_t;

    vec_t        tbl[12];
    logic [15:0] s_in[32];
    logic [7:0]  s_out[32];
    int          total = 0;
    int          bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // mode 0: sink stalls for 3 cycles then accepts; mode 1: random sink
    task automatic stream(input int nb, input int mode);
        logic [7:0] exp_q[$];
        int sent = 0;
        int got = 0;
        logic acc, drn;
        for (int c = 0; c < 300 && got < nb; c++) begin
            bus.data_in_0_valid = (sent < nb);
            bus.data_in_0[0] = s_in[sent % 32];
            if (mode == 0) bus.data_out_0_ready = (c >= 3);
            else bus.data_out_0_ready = 1'($urandom_range(0, 1));
            acc = bus.data_in_0_valid && bus.data_in_0_ready;
            drn = bus.data_out_0_valid && bus.data_out_0_ready;
            if (drn) begin
                if (exp_q.size() == 0) chk("stream_extra", 32'(bus.data_out_0), 32'hxx);
                else chk("stream_data", 32'(bus.data_out_0), 32'(exp_q.pop_front()));
                got++;
            end
            if (acc) begin
                exp_q.push_back(s_out[sent]);
                sent++;
            end
            step();
            if (mode == 0 && (c == 1 || c == 2)) begin
                chk("bp_in_ready", 32'(bus.data_in_0_ready), 32'd0);
                chk("bp_hold", 32'(bus.data_out_0), 32'h01);
                chk("bp_valid", 32'(bus.data_out_0_valid), 32'd1);
                chk("bp_sent", 32'(sent), 32'd2);
            end
        end
        bus.data_in_0_valid = 1'b0;
        chk("stream_count", 32'(got), 32'(nb));
        chk("stream_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        tbl[0]  = '{16'h0018, 8'h02, 0};
        tbl[1]  = '{16'h0008, 8'h01, 0};
        tbl[2]  = '{16'hFFF8, 8'h00, 0};
        tbl[3]  = '{16'h0800, 8'h7F, 1};
        tbl[4]  = '{16'h07F8, 8'h7F, 2};
        tbl[5]  = '{16'hF800, 8'h80, 2};
        tbl[6]  = '{16'hF7F0, 8'h80, 3};
        tbl[7]  = '{16'h0017, 8'h01, 3};
        tbl[8]  = '{16'hFFF7, 8'hFF, 3};
        tbl[9]  = '{16'h7FFF, 8'h7F, 4};
        tbl[10] = '{16'h8000, 8'h80, 5};
        tbl[11] = '{16'h0010, 8'h01, 5};

        bus.data_in_0 = '0;
        bus.data_in_0_valid = 1'b0;
        bus.data_out_0_ready = 1'b1;
        bus2.data_in_0 = '0;
        bus2.data_in_0_valid = 1'b0;
        bus2.data_out_0_ready = 1'b1;

        rst = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(bus.data_out_0_valid), 32'd0);
        chk("rst_ready", 32'(bus.data_in_0_ready), 32'd0);
        chk("rst_data", 32'(bus.data_out_0), 32'd0);
        chk("rst_cnt", bus.sat_count, 32'd0);
        rst = 1'b0;
        step();
        chk("ready_rise", 32'(bus.data_in_0_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            bus.data_in_0[0] = tbl[i].din;
            bus.data_in_0_valid = 1'b1;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(bus.data_out_0_valid), 32'd1);
            chk($sformatf("tbl%0d_data", i), 32'(bus.data_out_0), 32'(tbl[i].dout));
            chk($sformatf("tbl%0d_cnt", i), bus.sat_count, tbl[i].cnt);
        end
        bus.data_in_0_valid = 1'b0;
        step();
        chk("drain_valid", 32'(bus.data_out_0_valid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            s_in[i] = 16'(16 * (i + 1));
            s_out[i] = 8'(i + 1);
        end
        stream(5, 0);

        for (int i = 0; i < 24; i++) begin
            s_in[i] = tbl[i % 12].din;
            s_out[i] = tbl[i % 12].dout;
        end
        stream(24, 1);
        bus.data_out_0_ready = 1'b1;
        step();
        chk("rand_cnt", bus.sat_count, 32'd15);

        bus.data_out_0_ready = 1'b0;
        bus.data_in_0_valid = 1'b1;
        bus.data_in_0[0] = 16'h0800;
        step();
        bus.data_in_0[0] = 16'h0010;
        step();
        chk("two_ready", 32'(bus.data_in_0_ready), 32'd0);
        chk("two_cnt", bus.sat_count, 32'd16);
        rst = 1'b1;
        bus.data_in_0[0] = 16'h0020;
        bus.data_out_0_ready = 1'b1;
        step();
        rst = 1'b0;
        bus.data_in_0_valid = 1'b0;
        chk("mid_rst_valid", 32'(bus.data_out_0_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.data_in_0_ready), 32'd0);
        chk("mid_rst_cnt", bus.sat_count, 32'd0);
        chk("mid_rst_data", 32'(bus.data_out_0), 32'd0);
        step();
        chk("post_rst_ready", 32'(bus.data_in_0_ready), 32'd1);
        chk("post_rst_valid", 32'(bus.data_out_0_valid), 32'd0);
        bus.data_in_0[0] = 16'h0010;
        bus.data_in_0_valid = 1'b1;
        step();
        bus.data_in_0_valid = 1'b0;
        chk("post_rst_beat_v", 32'(bus.data_out_0_valid), 32'd1);
        chk("post_rst_beat_d", 32'(bus.data_out_0), 32'h01);
        step();
        chk("post_rst_empty", 32'(bus.data_out_0_valid), 32'd0);

        bus2.data_in_0[0] = 16'h0800;
        bus2.data_in_0[1] = 16'hF7F0;
        step();
        for (int i = 0; i < 9; i++) begin
            bus2.data_in_0_valid = 1'b1;
            step();
            chk($sformatf("ctr%0d", i), 32'(bus2.sat_count),
                (2 * (i + 1) > 15) ? 32'd15 : 32'(2 * (i + 1)));
            chk($sformatf("ctr%0d_data", i), 32'(bus2.data_out_0), 32'h807F);
        end
        bus2.data_in_0_valid = 1'b0;
        step();
        chk("ctr_hold", 32'(bus2.sat_count), 32'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fixed_act_input_requant.md
# fixed_act_input_requant

Streaming requantization stage directly upstream of the fixed-point LUT activations (sigmoid, etc.). Takes wide fixed-point results from the preceding linear/accumulate stage and rounds them half-up to the activation's narrow input format, saturating on overflow. Output is registered behind a 2-entry skid buffer. The emitted two's-complement bit pattern is used unchanged as the unsigned LUT address by the downstream activation.

## Interface
- DATA_IN_0_PRECISION_0, 16, input total width (two's complement)
- DATA_IN_0_PRECISION_1, 8, input fractional bits
- DATA_OUT_0_PRECISION_0, 8, output total width (= activation LUT address width)
- DATA_OUT_0_PRECISION_1, 4, output fractional bits
- DATA_IN_0_PARALLELISM_DIM_0, 1; DATA_IN_0_PARALLELISM_DIM_1, 1: lanes per beat, N = DIM_0*DIM_1
- SAT_COUNT_WIDTH, 32, width of the saturation statistics counter
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in_0  in  [DATA_IN_0_PRECISION_0-1:0] x N  wide input lanes
- data_in_0_valid  in  1  input beat valid
- data_in_0_ready  out  1  input beat accepted when valid&&ready
- data_out_0  out  [DATA_OUT_0_PRECISION_0-1:0] x N  requantized lanes
- data_out_0_valid  out  1  output beat valid
- data_out_0_ready  in  1  downstream accepts
- sat_count  out  SAT_COUNT_WIDTH  total saturated lanes since reset

## Operation
- Per lane: S = IN_FRAC - OUT_FRAC. Elaboration $error if S < 0 or (IN_W-IN_FRAC) < (OUT_W-OUT_FRAC).
- Rounding: sign-extend to IN_W+1 bits; if S>0, add 1<<(S-1); then arithmetic right shift by S (floor(x*2^-S + 0.5)). S=0: no rounding.
- Saturation: result > 2^(OUT_W-1)-1 -> 0x7F-pattern (max); < -2^(OUT_W-1) -> min (0x80-pattern). Otherwise low OUT_W bits.
- Saturated flag per lane; on each accepted input beat sat_count += popcount(flags); counter sticks at all-ones, never wraps.
- Requantization done combinationally at the input; results (with flags) stored in output register or skid register.
- FSM (shared package enum): EMPTY (no data held), ONE (output reg valid), TWO (output and skid valid).
  - EMPTY: accept -> ONE.
  - ONE: accept&&!drain -> TWO; drain&&!accept -> EMPTY; both -> ONE (output reg reloaded).
  - TWO: drain -> ONE (skid moves to output reg); no accept possible.
- accept = data_in_0_valid && data_in_0_ready; drain = data_out_0_valid && data_out_0_ready.
- data_in_0_ready is a register: 1 in EMPTY/ONE, 0 in TWO; no combinational path from data_out_0_ready.
- Order preserved strictly; no beat dropped or duplicated.

## Timing
- Latency 1 cycle: beat accepted at edge k is on data_out_0 with valid high after edge k.
- Throughput 1 beat/cycle when data_out_0_ready held high.
- data_out_0 stable while valid && !ready (AXI-style).
- Reset values: data_out_0_valid=0, data_out_0 lanes=0, data_in_0_ready=0, sat_count=0, state EMPTY. ready rises the first cycle after rst deasserts.
- rst mid-stream: all held beats discarded, no partial output, counter cleared; rst overrides simultaneous accept/drain.
- Saturation counter updated the edge the beat is accepted, not when it drains.

## Structure
- Package fixed_act_pkg: state enum (EMPTY/ONE/TWO), function computing rounding shift and saturation bounds from parameters.
- Sub-module fixed_round_sat: combinational single-lane round+saturate, outputs value and sat flag; instantiated N times via generate.
- Top holds FSM, output/skid registers, popcount and counter.

## Test plan
- Defaults (Q8.8 -> Q8.4), ready high: inputs 0x0018, 0x0008, 0xFFF8 -> outputs 0x02, 0x01, 0x00 on consecutive cycles, 1-cycle latency, sat_count 0.
- Saturation: 0x0800, 0x07F8, 0xF800, 0xF7F0 -> 0x7F, 0x7F, 0x80, 0x80; sat_count = 3 (0xF800 exact min, not saturated).
- Backpressure: 5 back-to-back beats, data_out_0_ready low 3 cycles -> data_in_0_ready drops after 2 accepted, data_out_0 stable, all 5 emerge in order after release.
- Simultaneous accept+drain in ONE state for 20 cycles with random ready -> no loss/duplication versus scoreboard.
- Reset mid-stream with TWO state -> next cycle valid=0, ready=0, sat_count=0; subsequent beat 0x0010 -> 0x01.
- Counter saturation with SAT_COUNT_WIDTH=4, N=2: drive 9 beats of two saturating lanes -> sat_count holds 0xF.
